// File: rtl/mc_control_unit_if.sv
// Control bus between the multicycle RV32I controller and its datapath.
// The master side is the controller: it reads the instruction fields and ALU flag
// and drives every select and write enable.
interface mc_control_unit_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [2:0] ALUControl;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegWrite, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegWrite, illegal
    );
endinterface

// File: rtl/mc_control_unit.sv
// Moore FSM controller for a multicycle RV32I datapath (lw, sw, R/I ALU ops, beq, jal).
// State-determined controls are registered together with the state; the few controls
// that depend on instruction fields or the zero flag are resolved combinationally from
// registered selector bits. Write enables are gated by the async reset so an aborted
// instruction cannot write anything while reset is held.
module mc_control_unit #(
    parameter bit TRAP_EN = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    mc_control_unit_if.master   bus,
    output logic [CNT_W-1:0]    instret
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       imm_by_op;  // ImmSrc follows the opcode (DECODE, MEMADR)
        logic       illegal;
    } ctrl_t;

    state_t           state_q, state_d;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] instret_q;

    logic is_lw, is_sw, is_r, is_i, is_beq, is_jal, alu_f3_ok, legal;
    logic [1:0] imm_op;

    // Control word asserted while sitting in a given state.
    function automatic ctrl_t ctrl_for(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.irwrite = 1'b1; c.srcb = 2'b10; c.resultsrc = 2'b10; c.pcupdate = 1'b1; end
            S_DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; c.imm_by_op = 1'b1; end
            S_MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; c.imm_by_op = 1'b1; end
            S_MEMREAD:  begin c.adrsrc = 1'b1; end
            S_MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
            S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
            S_EXECR:    begin c.srca = 2'b10; c.aluop = ALUOP_FUNCT; end
            S_EXECI:    begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = ALUOP_FUNCT; end
            S_ALUWB:    begin c.regwrite = 1'b1; end
            S_BEQ:      begin c.srca = 2'b10; c.aluop = ALUOP_SUB; c.branch = 1'b1; end
            S_JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcupdate = 1'b1; end
            S_TRAP:     begin c.illegal = 1'b1; end
            default:    ;
        endcase
        return c;
    endfunction

    // Instruction class and legality of the latched encoding.
    always_comb begin
        is_lw     = (bus.op == 7'b0000011);
        is_sw     = (bus.op == 7'b0100011);
        is_r      = (bus.op == 7'b0110011);
        is_i      = (bus.op == 7'b0010011);
        is_beq    = (bus.op == 7'b1100011);
        is_jal    = (bus.op == 7'b1101111);
        alu_f3_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
        legal     = ((is_lw || is_sw) && (bus.funct3 == 3'b010)) ||
                    ((is_r || is_i) && alu_f3_ok) ||
                    (is_beq && (bus.funct3 == 3'b000)) ||
                    is_jal;
        imm_op    = is_sw  ? 2'b01 :
                    is_beq ? 2'b10 :
                    is_jal ? 2'b11 : 2'b00;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                if (!legal)              state_d = TRAP_EN ? S_TRAP : S_FETCH;
                else if (is_lw || is_sw) state_d = S_MEMADR;
                else if (is_r)           state_d = S_EXECR;
                else if (is_i)           state_d = S_EXECI;
                else if (is_beq)         state_d = S_BEQ;
                else                     state_d = S_JAL;
            end
            S_MEMADR:   state_d = is_lw ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // State, registered control word and retired-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            ctrl_q    <= ctrl_for(S_FETCH);
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d);
            if (state_q == S_MEMWB || state_q == S_MEMWRITE ||
                state_q == S_ALUWB || state_q == S_BEQ)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    // ALU operation: fixed add/sub, or decoded from funct3/funct7b5.
    always_comb begin
        bus.ALUControl = 3'b000;
        case (ctrl_q.aluop)
            ALUOP_SUB: bus.ALUControl = 3'b001;
            ALUOP_FUNCT: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.ALUControl = 3'b101;
                    3'b110:  bus.ALUControl = 3'b011;
                    3'b111:  bus.ALUControl = 3'b010;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
            default: bus.ALUControl = 3'b000;
        endcase
    end

    assign bus.PCWrite   = rst & (ctrl_q.pcupdate | (ctrl_q.branch & bus.zero));
    assign bus.MemWrite  = rst & ctrl_q.memwrite;
    assign bus.IRWrite   = rst & ctrl_q.irwrite;
    assign bus.RegWrite  = rst & ctrl_q.regwrite;
    assign bus.AdrSrc    = ctrl_q.adrsrc;
    assign bus.ResultSrc = ctrl_q.resultsrc;
    assign bus.ALUSrcA   = ctrl_q.srca;
    assign bus.ALUSrcB   = ctrl_q.srcb;
    assign bus.ImmSrc    = ctrl_q.imm_by_op ? imm_op : 2'b00;
    assign bus.illegal   = ctrl_q.illegal;
    assign instret       = instret_q;

endmodule
